// File: rtl/mdu_ctrl.sv
// Multiply/divide controller beside Ex: owns HI/LO, models fixed mult/div latency
// with a down-counter, and raises the start/busy/stall hazard signals.
//
// state | meaning
// IDLE  | no operation in flight; mthi/mtlo and starts accepted
// RUN   | counting down a mult/div; result commits when cnt reaches 1
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_Ex,
    input  logic [3:0]  op_Ex,
    input  logic [31:0] srcA_Ex,
    input  logic [31:0] srcB_Ex,
    input  logic        mdu_Id,
    output logic        start_Ss,
    output logic        busy_Ss,
    output logic        stall_Ss,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_Ex
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [15:0] cnt;
    logic        upd;
    logic [31:0] phi;
    logic [31:0] plo;

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [31:0] divisorS;
    logic [31:0] divisorU;
    logic [31:0] qMag;
    logic [31:0] rMag;
    logic [31:0] nextHi;
    logic [31:0] nextLo;
    logic        nextUpd;
    logic [15:0] loadCnt;

    assign start_Ss = issue_Ex && (op_Ex == OP_MULT || op_Ex == OP_MULTU ||
                                   op_Ex == OP_DIV  || op_Ex == OP_DIVU);
    assign busy_Ss  = (state == RUN);
    assign stall_Ss = mdu_Id && (start_Ss || busy_Ss);

    always_comb begin
        rd_Ex = 32'd0;
        if (op_Ex == OP_MFHI)
            rd_Ex = hi;
        else if (op_Ex == OP_MFLO)
            rd_Ex = lo;
    end

    // Signed divide is done on magnitudes; a zero divisor is replaced by 1 so the
    // datapath never yields X, and upd suppresses the commit in that case.
    always_comb begin
        prodS    = {{32{srcA_Ex[31]}}, srcA_Ex} * {{32{srcB_Ex[31]}}, srcB_Ex};
        prodU    = {32'd0, srcA_Ex} * {32'd0, srcB_Ex};
        absA     = srcA_Ex[31] ? -srcA_Ex : srcA_Ex;
        absB     = srcB_Ex[31] ? -srcB_Ex : srcB_Ex;
        divisorS = (srcB_Ex == 32'd0) ? 32'd1 : absB;
        divisorU = (srcB_Ex == 32'd0) ? 32'd1 : srcB_Ex;
        qMag     = absA / divisorS;
        rMag     = absA % divisorS;
        nextHi   = 32'd0;
        nextLo   = 32'd0;
        nextUpd  = 1'b1;
        loadCnt  = 16'(DIV_CYCLES);
        case (op_Ex)
            OP_MULT: begin
                nextHi  = prodS[63:32];
                nextLo  = prodS[31:0];
                loadCnt = 16'(MULT_CYCLES);
            end
            OP_MULTU: begin
                nextHi  = prodU[63:32];
                nextLo  = prodU[31:0];
                loadCnt = 16'(MULT_CYCLES);
            end
            OP_DIV: begin
                nextLo  = (srcA_Ex[31] ^ srcB_Ex[31]) ? -qMag : qMag;
                nextHi  = srcA_Ex[31] ? -rMag : rMag;
                nextUpd = (srcB_Ex != 32'd0);
            end
            OP_DIVU: begin
                nextLo  = srcA_Ex / divisorU;
                nextHi  = srcA_Ex % divisorU;
                nextUpd = (srcB_Ex != 32'd0);
            end
            default: nextUpd = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 16'd0;
            upd   <= 1'b0;
            phi   <= 32'd0;
            plo   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_Ss) begin
                        state <= RUN;
                        cnt   <= loadCnt;
                        phi   <= nextHi;
                        plo   <= nextLo;
                        upd   <= nextUpd;
                    end else if (issue_Ex && op_Ex == OP_MTHI) begin
                        hi <= srcA_Ex;
                    end else if (issue_Ex && op_Ex == OP_MTLO) begin
                        lo <= srcA_Ex;
                    end
                end
                RUN: begin
                    cnt <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        state <= IDLE;
                        if (upd) begin
                            hi <= phi;
                            lo <= plo;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
